// File: rtl/alu_if.sv
// alu_if: operand/opcode request and result/status response of alu_core.
//   master: drives in1, in2, alu_op; observes alu_out, z
//   slave : observes in1, in2, alu_op; drives alu_out, z
interface alu_if #(
  parameter int N = 12
);
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_out;
  logic [N-1:0] z;

  modport master (output in1, in2, alu_op, input alu_out, z);
  modport slave  (input in1, in2, alu_op, output alu_out, z);
endinterface

// File: rtl/alu_core.sv
// alu_core: registered signed two's-complement ALU, one op per cycle, latency 1.
//   clk    : clock, rising edge
//   rst_n  : async active-low reset, clears alu_out and z
//   bus    : alu_if.slave -- in1, in2, alu_op in; alu_out, z (status) out
// Status z: [0] zero, [1] negative, [2] carry/borrow/mul-lost, [3] overflow.
// Optional build macro ALU_MUL_EN: enables the signed multiplier for op 2;
// without it op 2 yields 0 with only the zero flag set.
module alu_core #(
  parameter int N              = 12,
  parameter int width_of_index = 6
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_NEG   = 3'd3,
    OP_INDEX = 3'd4,
    OP_PASSA = 3'd5,
    OP_PASSB = 3'd6,
    OP_ZERO  = 3'd7
  } op_e;

  typedef struct packed {
    logic [N-1:0] r;
    logic         c;
    logic         v;
  } res_t;

  logic [N-1:0] a, b, a_shl;
  logic [N:0]   add_s, sub_d, neg_d, idx_s;
  res_t         res;
  logic [N-1:0] st;

`ifdef ALU_MUL_EN
  logic signed [2*N-1:0] prod;
  assign prod = $signed(a) * $signed(b);
`endif

  assign a     = bus.in1;
  assign b     = bus.in2;
  assign a_shl = a << width_of_index;
  // one extra MSB captures unsigned carry / borrow
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_d = {1'b0, a} - {1'b0, b};
  assign neg_d = {(N+1){1'b0}} - {1'b0, b};
  assign idx_s = {1'b0, a_shl} + {1'b0, b};

  always_comb begin
    res = '0;
    unique case (op_e'(bus.alu_op))
      OP_ADD: begin
        res.r = add_s[N-1:0];
        res.c = add_s[N];
        res.v = (a[N-1] == b[N-1]) && (add_s[N-1] != a[N-1]);
      end
      OP_SUB: begin
        res.r = sub_d[N-1:0];
        res.c = sub_d[N];
        res.v = (a[N-1] != b[N-1]) && (sub_d[N-1] != a[N-1]);
      end
      OP_MUL: begin
`ifdef ALU_MUL_EN
        res.r = prod[N-1:0];
        // product lost information if it differs from its truncation re-extended
        res.c = (prod != {{N{prod[N-1]}}, prod[N-1:0]});
        res.v = res.c;
`else
        res = '0;
`endif
      end
      OP_NEG: begin
        res.r = neg_d[N-1:0];
        res.c = neg_d[N];
        // only the most negative value overflows on negation
        res.v = b[N-1] && neg_d[N-1];
      end
      OP_INDEX: begin
        res.r = idx_s[N-1:0];
        res.c = idx_s[N];
      end
      OP_PASSA: res.r = a;
      OP_PASSB: res.r = b;
      OP_ZERO:  res.r = '0;
      default:  res = '0;
    endcase
  end

  always_comb begin
    st    = '0;
    st[0] = (res.r == '0);
    st[1] = res.r[N-1];
    st[2] = res.c;
    st[3] = res.v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out <= '0;
      bus.z       <= '0;
    end else begin
      bus.alu_out <= res.r;
      bus.z       <= st;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;
  localparam int N = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total    = 0;

  alu_if #(.N(N)) bus ();

  alu_core #(.N(N), .width_of_index(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // drive on falling edge, sample 1ns after the next rising edge
  task automatic apply(input logic [N-1:0] x, input logic [N-1:0] y, input logic [2:0] op);
    @(negedge clk);
    bus.in1    = x;
    bus.in2    = y;
    bus.alu_op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] out_exp, input logic [N-1:0] z_exp);
    total++;
    if (bus.alu_out !== out_exp || bus.z !== z_exp)
      $display("FAIL %s: out=%h z=%h expected out=%h z=%h", name, bus.alu_out, bus.z, out_exp, z_exp);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    apply(12'd7, 12'd9, 3'd0);      // leave a nonzero result in the registers
    @(negedge clk);
    #2;
    bus.in1 = 12'd5; bus.in2 = 12'd10; bus.alu_op = 3'd0;
    rst_n = 1'b0;                   // mid-cycle, no clock edge
    #1;
    total++;
    if (bus.alu_out !== 12'h000 || bus.z !== 12'h000)
      $display("FAIL reset_async: out=%h z=%h expected out=000 z=000", bus.alu_out, bus.z);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.alu_out !== 12'h000 || bus.z !== 12'h000)
      $display("FAIL reset_hold: out=%h z=%h expected out=000 z=000", bus.alu_out, bus.z);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.alu_out !== 12'd15 || bus.z !== 12'h000)
      $display("FAIL reset_release: out=%h z=%h expected out=00f z=000", bus.alu_out, bus.z);
    else pass_cnt++;
  endtask

  task automatic test_add();
    apply(12'd5, 12'd10, 3'd0);
    chk("add_5_10", 12'd15, 12'h000);
    apply(12'd30, 12'd10, 3'd0);
    chk("add_30_10", 12'd40, 12'h000);
    apply(12'h7FF, 12'h001, 3'd0);
    chk("add_ovf", 12'h800, 12'h00A);
    apply(12'hFFF, 12'h001, 3'd0);
    chk("add_carry", 12'h000, 12'h005);
  endtask

  task automatic test_sub();
    apply(12'd5, 12'd10, 3'd1);
    chk("sub_neg", 12'hFFB, 12'h006);
    apply(12'd10, 12'd10, 3'd1);
    chk("sub_zero", 12'h000, 12'h001);
    apply(12'h800, 12'h001, 3'd1);
    chk("sub_ovf", 12'h7FF, 12'h008);
  endtask

  task automatic test_mul();
`ifdef ALU_MUL_EN
    apply(12'd4, 12'd20, 3'd2);
    chk("mul_4_20", 12'd80, 12'h000);
    apply(12'h100, 12'h010, 3'd2);
    chk("mul_lost", 12'h000, 12'h00D);
    apply(12'hFFD, 12'd5, 3'd2);     // -3 * 5 = -15, fits
    chk("mul_neg", 12'hFF1, 12'h002);
`else
    apply(12'd4, 12'd20, 3'd2);
    chk("mul_off", 12'h000, 12'h001);
`endif
  endtask

  task automatic test_index();
    apply(12'd4, 12'd20, 3'd4);
    chk("index_4_20", 12'h114, 12'h000);
    apply(12'd6, 12'd20, 3'd4);
    chk("index_6_20", 12'h194, 12'h000);
    apply(12'd63, 12'd63, 3'd4);
    chk("index_max", 12'hFFF, 12'h002);
    apply(12'd63, 12'h040, 3'd4);    // 0xFC0 + 0x040 carries out
    chk("index_carry", 12'h000, 12'h005);
  endtask

  task automatic test_misc_ops();
    apply(12'd5, 12'd10, 3'd3);
    chk("neg", 12'hFF6, 12'h006);
    apply(12'd5, 12'h800, 3'd3);
    chk("neg_min", 12'h800, 12'h00E);
    apply(12'd5, 12'd10, 3'd5);
    chk("passa", 12'd5, 12'h000);
    apply(12'd5, 12'd10, 3'd6);
    chk("passb", 12'd10, 12'h000);
    apply(12'd5, 12'd10, 3'd7);
    chk("zero", 12'h000, 12'h001);
  endtask

  task automatic test_back_to_back();
    apply(12'd5, 12'd10, 3'd5);
    chk("b2b_passa", 12'd5, 12'h000);
    apply(12'd5, 12'd10, 3'd6);
    chk("b2b_passb", 12'd10, 12'h000);
    apply(12'd5, 12'd10, 3'd1);
    chk("b2b_sub", 12'hFFB, 12'h006);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in1 = '0; bus.in2 = '0; bus.alu_op = '0;
    #12;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_index();
    test_misc_ops();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
